// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified-memory port arbiter.
package mem_arb_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } state_e;

    localparam logic SEL_INSTR = 1'b0;
    localparam logic SEL_DATA  = 1'b1;

    localparam int DEF_STARVE_LIM = 4;
    localparam int DEF_TIMEOUT    = 16;

endpackage

// File: rtl/arb_priority.sv
// Combinational winner selection: D-side by default, I-side once it has
// lost STARVE_LIM arbitrations in a row.
module arb_priority
    import mem_arb_pkg::*;
#(
    parameter int STARVE_LIM = DEF_STARVE_LIM,
    parameter int CNT_W      = 3
) (
    input  logic             i_req,
    input  logic             d_req,
    input  logic [CNT_W-1:0] starve_cnt,
    output logic [1:0]       gnt,
    output logic             winner
);

    logic force_i;

    assign force_i = i_req && (starve_cnt == CNT_W'(STARVE_LIM));

    always_comb begin
        gnt    = '0;
        winner = SEL_INSTR;
        if (d_req && !force_i) begin
            gnt[SEL_DATA] = 1'b1;
            winner        = SEL_DATA;
        end else if (i_req) begin
            gnt[SEL_INSTR] = 1'b1;
            winner         = SEL_INSTR;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between instruction fetch and load/store,
// with a registered memory port, per-transaction timeout and anti-starvation.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_LIM = DEF_STARVE_LIM,
    parameter int TIMEOUT    = DEF_TIMEOUT
) (
    input  logic                clk,
    input  logic                rst,

    input  logic                i_req,
    input  logic [ADDR_W-1:0]   i_addr,
    output logic                i_gnt,
    output logic                i_rvalid,
    output logic [DATA_W-1:0]   i_rdata,
    output logic                i_err,

    input  logic                d_req,
    input  logic                d_we,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    input  logic [DATA_W/8-1:0] d_be,
    output logic                d_gnt,
    output logic                d_rvalid,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                d_err,

    output logic                mem_req,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_be,
    input  logic                mem_ack,
    input  logic [DATA_W-1:0]   mem_rdata,

    output logic                sel,
    output logic                busy
);

    localparam int SW = $clog2(STARVE_LIM + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    state_e        state;
    logic [SW-1:0] starve_cnt;
    logic [TW-1:0] tmo_cnt;
    logic [1:0]    gnt_raw;
    logic          winner;
    logic          grant_ok;
    logic          tmo_hit;

    arb_priority #(
        .STARVE_LIM (STARVE_LIM),
        .CNT_W      (SW)
    ) u_prio (
        .i_req      (i_req),
        .d_req      (d_req),
        .starve_cnt (starve_cnt),
        .gnt        (gnt_raw),
        .winner     (winner)
    );

    // Grants are suppressed during reset so a requester never sees an
    // acceptance that the reset is about to discard.
    assign grant_ok = (state == IDLE) && !rst;
    assign i_gnt    = grant_ok && gnt_raw[SEL_INSTR];
    assign d_gnt    = grant_ok && gnt_raw[SEL_DATA];
    assign busy     = (state == ISSUE);
    assign tmo_hit  = (state == ISSUE) && !mem_ack && (tmo_cnt == TW'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            tmo_cnt   <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_be    <= '0;
            sel       <= SEL_INSTR;
            i_rvalid  <= 1'b0;
            i_rdata   <= '0;
            i_err     <= 1'b0;
            d_rvalid  <= 1'b0;
            d_rdata   <= '0;
            d_err     <= 1'b0;
        end else begin
            i_rvalid <= 1'b0;
            i_rdata  <= '0;
            i_err    <= 1'b0;
            d_rvalid <= 1'b0;
            d_rdata  <= '0;
            d_err    <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_gnt || d_gnt) begin
                        state   <= ISSUE;
                        mem_req <= 1'b1;
                        sel     <= winner;
                        tmo_cnt <= '0;
                        if (winner == SEL_DATA) begin
                            mem_we    <= d_we;
                            mem_addr  <= d_addr;
                            mem_wdata <= d_wdata;
                            mem_be    <= d_be;
                        end else begin
                            mem_we    <= 1'b0;
                            mem_addr  <= i_addr;
                            mem_wdata <= '0;
                            mem_be    <= '1;
                        end
                    end
                end
                ISSUE: begin
                    // Ack beats the timeout when both land in the same cycle.
                    if (mem_ack) begin
                        state   <= IDLE;
                        mem_req <= 1'b0;
                        if (sel == SEL_DATA) begin
                            d_rvalid <= 1'b1;
                            d_rdata  <= mem_we ? '0 : mem_rdata;
                        end else begin
                            i_rvalid <= 1'b1;
                            i_rdata  <= mem_rdata;
                        end
                    end else if (tmo_hit) begin
                        state   <= IDLE;
                        mem_req <= 1'b0;
                        if (sel == SEL_DATA) begin
                            d_rvalid <= 1'b1;
                            d_err    <= 1'b1;
                        end else begin
                            i_rvalid <= 1'b1;
                            i_err    <= 1'b1;
                        end
                    end else begin
                        tmo_cnt <= tmo_cnt + TW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt <= '0;
        end else if (i_gnt) begin
            starve_cnt <= '0;
        end else if (d_gnt && i_req && (starve_cnt != SW'(STARVE_LIM))) begin
            starve_cnt <= starve_cnt + SW'(1);
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: fetch, contention, starvation,
// timeout, boundary ack and mid-transaction reset.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_gnt, i_rvalid, i_err;
    logic [31:0] i_rdata;
    logic        d_req, d_we;
    logic [31:0] d_addr, d_wdata;
    logic [3:0]  d_be;
    logic        d_gnt, d_rvalid, d_err;
    logic [31:0] d_rdata;
    logic        mem_req, mem_we, mem_ack;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_be;
    logic        sel, busy;

    int errors = 0;
    int checks = 0;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIM(4), .TIMEOUT(16)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid),
        .i_rdata(i_rdata), .i_err(i_err),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_be(mem_be), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .sel(sel), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++;
        if ({mem_req, mem_we, mem_addr, mem_wdata, mem_be, sel, busy} !== '0) begin
            errors++;
            $display("FAIL reset_mem: got req=%b addr=%h sel=%b busy=%b exp all 0", mem_req, mem_addr, sel, busy);
        end
        checks++;
        if ({i_gnt, i_rvalid, i_rdata, i_err, d_gnt, d_rvalid, d_rdata, d_err} !== '0) begin
            errors++;
            $display("FAIL reset_resp: got i_rv=%b d_rv=%b i_gnt=%b d_gnt=%b exp all 0", i_rvalid, d_rvalid, i_gnt, d_gnt);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_lone_fetch();
        i_req = 1'b1; i_addr = 32'h100;
        #1;
        checks++;
        if (i_gnt !== 1'b1 || d_gnt !== 1'b0) begin
            errors++; $display("FAIL fetch_gnt: got i_gnt=%b d_gnt=%b exp 1 0", i_gnt, d_gnt);
        end
        tick();
        i_req = 1'b0;
        checks++;
        if ({mem_req, sel, mem_we, mem_be, mem_addr, busy} !== {1'b1, 1'b0, 1'b0, 4'hF, 32'h100, 1'b1}) begin
            errors++;
            $display("FAIL fetch_issue: got req=%b sel=%b we=%b be=%h addr=%h busy=%b exp 1 0 0 f 100 1",
                     mem_req, sel, mem_we, mem_be, mem_addr, busy);
        end
        tick();
        mem_ack = 1'b1; mem_rdata = 32'h00500093;
        checks++;
        if (i_rvalid !== 1'b0 || mem_req !== 1'b1) begin
            errors++; $display("FAIL fetch_hold: got i_rvalid=%b mem_req=%b exp 0 1", i_rvalid, mem_req);
        end
        tick();
        mem_ack = 1'b0; mem_rdata = '0;
        checks++;
        if ({i_rvalid, i_rdata, i_err, d_rvalid, d_gnt, mem_req} !== {1'b1, 32'h00500093, 1'b0, 1'b0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL fetch_resp: got i_rv=%b i_rdata=%h i_err=%b d_rv=%b mem_req=%b exp 1 00500093 0 0 0",
                     i_rvalid, i_rdata, i_err, d_rvalid, mem_req);
        end
        tick();
        checks++;
        if (i_rvalid !== 1'b0) begin
            errors++; $display("FAIL fetch_pulse: got i_rvalid=%b exp 0", i_rvalid);
        end
    endtask

    task automatic test_contention();
        i_req = 1'b1; i_addr = 32'h104;
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h200; d_wdata = 32'hDEADBEEF; d_be = 4'hF;
        #1;
        checks++;
        if (d_gnt !== 1'b1 || i_gnt !== 1'b0) begin
            errors++; $display("FAIL cont_gnt: got d_gnt=%b i_gnt=%b exp 1 0", d_gnt, i_gnt);
        end
        tick();
        d_req = 1'b0; d_we = 1'b0;
        checks++;
        if ({sel, mem_we, mem_addr, mem_wdata, mem_be, i_gnt} !== {1'b1, 1'b1, 32'h200, 32'hDEADBEEF, 4'hF, 1'b0}) begin
            errors++;
            $display("FAIL cont_issue: got sel=%b we=%b addr=%h wdata=%h be=%h i_gnt=%b exp 1 1 200 deadbeef f 0",
                     sel, mem_we, mem_addr, mem_wdata, mem_be, i_gnt);
        end
        tick();
        mem_ack = 1'b1; mem_rdata = 32'h12345678;
        tick();
        mem_ack = 1'b0;
        #1;
        checks++;
        if ({d_rvalid, d_rdata, d_err, i_rvalid, i_gnt} !== {1'b1, 32'h0, 1'b0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL cont_store_resp: got d_rv=%b d_rdata=%h d_err=%b i_rv=%b i_gnt=%b exp 1 0 0 0 1",
                     d_rvalid, d_rdata, d_err, i_rvalid, i_gnt);
        end
        tick();
        i_req = 1'b0;
        checks++;
        if ({mem_req, sel, mem_addr} !== {1'b1, 1'b0, 32'h104}) begin
            errors++; $display("FAIL cont_fetch_issue: got req=%b sel=%b addr=%h exp 1 0 104", mem_req, sel, mem_addr);
        end
        mem_ack = 1'b1; mem_rdata = 32'h00A00113;
        tick();
        mem_ack = 1'b0;
        checks++;
        if ({i_rvalid, i_rdata, d_rvalid} !== {1'b1, 32'h00A00113, 1'b0}) begin
            errors++; $display("FAIL cont_fetch_resp: got i_rv=%b i_rdata=%h d_rv=%b exp 1 00a00113 0", i_rvalid, i_rdata, d_rvalid);
        end
        tick();
    endtask

    task automatic test_starvation();
        logic [6:0] exp_i;
        logic [6:0] got_i;
        int         n;
        exp_i = 7'b0010000;  // bit n = 1 when grant n must go to the I-side
        got_i = '0;
        n = 0;
        i_req = 1'b1; i_addr = 32'h180;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h280; d_be = 4'hF;
        for (int c = 0; c < 100 && n < 7; c++) begin
            mem_ack = mem_req; mem_rdata = 32'h0;
            #1;
            if (i_gnt && d_gnt) begin
                checks++; errors++;
                $display("FAIL starve_both_gnt: got i_gnt=1 d_gnt=1 exp at most one");
            end
            if (i_gnt || d_gnt) begin
                got_i[n] = i_gnt;
                n++;
            end
            @(posedge clk);
            #1;
        end
        checks++;
        if (n != 7) begin
            errors++; $display("FAIL starve_budget: got %0d grants exp 7", n);
        end
        for (int k = 0; k < 7; k++) begin
            checks++;
            if (got_i[k] !== exp_i[k]) begin
                errors++; $display("FAIL starve_grant%0d: got i_side=%b exp %b", k, got_i[k], exp_i[k]);
            end
        end
        i_req = 1'b0; d_req = 1'b0;
        for (int c = 0; c < 4; c++) begin
            mem_ack = mem_req;
            tick();
        end
        mem_ack = 1'b0;
        tick();
    endtask

    task automatic test_timeout();
        int hi;
        hi = 0;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h300; d_be = 4'h3;
        tick();
        d_req = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (!mem_req) break;
            hi++;
            tick();
        end
        checks++;
        if (hi != 16) begin
            errors++; $display("FAIL tmo_len: got mem_req high %0d cycles exp 16", hi);
        end
        checks++;
        if ({d_rvalid, d_err, d_rdata, i_rvalid, busy} !== {1'b1, 1'b1, 32'h0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL tmo_resp: got d_rv=%b d_err=%b d_rdata=%h i_rv=%b busy=%b exp 1 1 0 0 0",
                     d_rvalid, d_err, d_rdata, i_rvalid, busy);
        end
        d_req = 1'b1; d_addr = 32'h304;
        tick();
        d_req = 1'b0;
        mem_ack = 1'b1; mem_rdata = 32'hCAFEF00D;
        tick();
        mem_ack = 1'b0;
        checks++;
        if ({d_rvalid, d_err, d_rdata} !== {1'b1, 1'b0, 32'hCAFEF00D}) begin
            errors++; $display("FAIL tmo_next: got d_rv=%b d_err=%b d_rdata=%h exp 1 0 cafef00d", d_rvalid, d_err, d_rdata);
        end
        tick();
    endtask

    task automatic test_ack_boundary();
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h400; d_be = 4'hF;
        tick();
        d_req = 1'b0;
        for (int c = 1; c < 16; c++) tick();
        checks++;
        if (mem_req !== 1'b1) begin
            errors++; $display("FAIL bnd_still_issue: got mem_req=%b exp 1", mem_req);
        end
        mem_ack = 1'b1; mem_rdata = 32'hA5A5A5A5;
        tick();
        mem_ack = 1'b0;
        checks++;
        if ({d_rvalid, d_err, d_rdata, mem_req} !== {1'b1, 1'b0, 32'hA5A5A5A5, 1'b0}) begin
            errors++;
            $display("FAIL bnd_resp: got d_rv=%b d_err=%b d_rdata=%h mem_req=%b exp 1 0 a5a5a5a5 0",
                     d_rvalid, d_err, d_rdata, mem_req);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h500; d_wdata = 32'h11223344; d_be = 4'hF;
        tick();
        d_req = 1'b0; d_we = 1'b0;
        tick();
        rst = 1'b1; mem_ack = 1'b1; mem_rdata = 32'h55667788;
        tick();
        rst = 1'b0; mem_ack = 1'b0;
        checks++;
        if ({i_rvalid, d_rvalid, mem_req, mem_we, mem_addr, mem_wdata, mem_be, sel, busy} !== '0) begin
            errors++;
            $display("FAIL rstmid_out: got i_rv=%b d_rv=%b req=%b addr=%h sel=%b busy=%b exp all 0",
                     i_rvalid, d_rvalid, mem_req, mem_addr, sel, busy);
        end
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        checks++;
        if ({i_rvalid, d_rvalid, mem_req, busy} !== 4'b0000) begin
            errors++;
            $display("FAIL rstmid_late_ack: got i_rv=%b d_rv=%b req=%b busy=%b exp 0 0 0 0", i_rvalid, d_rvalid, mem_req, busy);
        end
    endtask

    initial begin
        rst = 1'b1;
        i_req = 1'b0; i_addr = '0;
        d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0; d_be = '0;
        mem_ack = 1'b0; mem_rdata = '0;
        test_reset();
        test_lone_fetch();
        test_contention();
        test_starvation();
        test_timeout();
        test_ack_boundary();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares one single-ported unified memory between the instruction-fetch requester (I-side) and the load/store requester (D-side).
- Arbitrates between the two sides, registers the winning request onto the memory port, and drives the datapath 2:1 address/data mux select.
- Returns responses to the originating side, with timeout and anti-starvation protection.
- Sits between the fetch/LSU stages and the memory wrapper, replacing direct memory hookup.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width
STARVE_LIM, 4, consecutive I-side losses before the I-side is forced to win
TIMEOUT, 16, cycles in ISSUE without mem_ack before the transaction is aborted

Ports:
clk  in  1  clock; all logic on rising edge
rst  in  1  synchronous, active-high reset
i_req  in  1  fetch request; held with i_addr stable until i_gnt
i_addr  in  ADDR_W  fetch address
i_gnt  out  1  fetch accepted this cycle
i_rvalid  out  1  one-cycle pulse; i_rdata/i_err valid
i_rdata  out  DATA_W  fetched word
i_err  out  1  fetch timed out
d_req  in  1  load/store request; fields held stable until d_gnt
d_we  in  1  1 = store
d_addr  in  ADDR_W  data address
d_wdata  in  DATA_W  store data
d_be  in  DATA_W/8  byte enables
d_gnt  out  1  data request accepted this cycle
d_rvalid  out  1  one-cycle pulse; load data or store completion
d_rdata  out  DATA_W  load data (0 for stores)
d_err  out  1  data access timed out
mem_req  out  1  memory request, held until mem_ack
mem_we  out  1  write strobe
mem_addr  out  ADDR_W  registered address
mem_wdata  out  DATA_W  registered write data
mem_be  out  DATA_W/8  registered byte enables (all-ones for fetch)
mem_ack  in  1  one-cycle completion; mem_rdata valid
mem_rdata  in  DATA_W  read data
sel  out  1  datapath mux select: 0 = I-side, 1 = D-side; registered
busy  out  1  high while in ISSUE

Behaviour:
- Reset:
  - rst is synchronous, active-high.
  - State goes to IDLE. All outputs are 0, including sel=0. Starvation counter and timeout counter are 0.
  - In-flight transactions are abandoned with no rvalid.
  - mem_ack arriving in IDLE is ignored.
- States: IDLE, ISSUE.
- IDLE:
  - Grant is combinational from req, same cycle.
  - Priority when both request: D-side wins, unless starve_cnt == STARVE_LIM, in which case the I-side wins.
  - On grant, next cycle: mem_* loaded from the winner, sel = winner, mem_req=1, state ISSUE, timeout counter cleared.
  - Fetch grants set mem_we=0 and mem_be=all-ones.
- Starvation counter:
  - Increments when I-side is requesting and D-side wins.
  - Clears on any I-side grant.
  - Saturates at STARVE_LIM.
- ISSUE:
  - mem_req, mem_* and sel are held constant; no grants are issued.
  - On mem_ack: the owner's rvalid pulses the next cycle, with rdata = registered mem_rdata (0 for stores) and err=0. State returns to IDLE the same edge.
  - A new grant is allowed in the cycle rvalid pulses.
  - Back-to-back throughput is one access per 2 cycles with a 1-cycle memory.
- Timeout:
  - The timeout counter increments each ISSUE cycle without ack.
  - When it reaches TIMEOUT-1 with no ack, the next edge drops mem_req, pulses the owner's rvalid with err=1 and rdata=0, and returns to IDLE.
  - mem_ack on that same cycle takes precedence: normal completion, err=0.
- Outputs:
  - The non-owning side's rvalid stays 0.
  - i_gnt and d_gnt are never high together.
  - Requests dropped before grant are legal and simply not served.
- rst asserted during ISSUE: rst wins over mem_ack and over the timeout.

Decomposition:
- Package mem_arb_pkg holds:
  - state enum IDLE/ISSUE
  - constants SEL_INSTR=0, SEL_DATA=1
  - default STARVE_LIM/TIMEOUT
- One natural sub-module: arb_priority, the combinational winner selection from i_req, d_req, starve_cnt, producing gnt vector plus winner id.
- Counters and FSM stay in the top module.

Test Plan:
- Lone fetch:
  - Stimulus: i_req, i_addr=0x100; mem_ack 1 cycle after mem_req, mem_rdata=0x00500093.
  - Required: i_gnt at cycle 0, mem_req/sel=0 at cycle 1, i_rvalid with 0x00500093 at cycle 3, d_* silent.
- Contention:
  - Stimulus: i_req and d_req (store 0xDEADBEEF to 0x200, be=0xF) asserted together, 1-cycle memory.
  - Required: d_gnt first, sel=1, mem_we=1; d_rvalid d_rdata=0; i_gnt in the d_rvalid cycle.
- Starvation:
  - Stimulus: d_req held high for 10 accesses, i_req held high.
  - Required: after 4 D grants the I-side is granted; starve_cnt returns to 0; D resumes.
- Timeout:
  - Stimulus: d_req load, mem_ack never asserted.
  - Required: mem_req high exactly 16 cycles, then d_rvalid with d_err=1 and d_rdata=0; next request served normally.
- Reset mid-operation:
  - Stimulus: rst during ISSUE with mem_ack the same cycle.
  - Required: no rvalid; all outputs 0 next cycle; a late mem_ack in IDLE is ignored.
- Ack at timeout boundary:
  - Stimulus: mem_ack arrives on the 16th ISSUE cycle.
  - Required: normal completion, err=0.
